// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin credit-based write scheduler in front of a shared FIFO
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int N_REQ      = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              req_ready,
    input  logic                          fifo_rd,
    output logic                          fifo_wr,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic [$clog2(FIFO_DEPTH):0]   credits,
    output logic                          err
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, STALL} state_t;

    state_t          state, state_next;
    logic            have_credit;
    logic            grant;
    logic            pop_ok;
    logic [IW-1:0]   rr_ptr, rr_next, winner;
    logic [IW:0]     scan;
    logic [DATA_WIDTH-1:0] win_data;

    // A pop in this cycle frees a slot that can be granted in the same cycle.
    always_comb begin
        have_credit = (credits != '0) || fifo_rd;
        pop_ok      = fifo_rd && (credits != DEPTH_C);
        winner      = rr_ptr;
        scan        = '0;
        req_ready   = '0;
        win_data    = '0;
        state_next  = state;

        // Descending offsets so the slot closest to rr_ptr is assigned last and wins.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            scan = {1'b0, rr_ptr} + (IW+1)'(i);
            if (scan >= (IW+1)'(N_REQ))
                scan = scan - (IW+1)'(N_REQ);
            if (req_valid[scan[IW-1:0]])
                winner = scan[IW-1:0];
        end

        grant = (|req_valid) && have_credit && !reset;
        if (grant)
            req_ready[winner] = 1'b1;

        for (int k = 0; k < N_REQ; k++) begin
            if (winner == IW'(k))
                win_data = req_data[k*DATA_WIDTH +: DATA_WIDTH];
        end

        rr_next = (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;

        case (state)
            IDLE: begin
                if (|req_valid)
                    state_next = have_credit ? ACTIVE : STALL;
            end
            ACTIVE: begin
                if (!(|req_valid))
                    state_next = IDLE;
                else if (!have_credit)
                    state_next = STALL;
            end
            STALL: begin
                if (!(|req_valid))
                    state_next = IDLE;
                else if (have_credit)
                    state_next = ACTIVE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A pop against an empty FIFO is flagged and never returns a credit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_wr  <= 1'b0;
            fifo_din <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
            credits  <= DEPTH_C;
            err      <= 1'b0;
        end else begin
            fifo_wr <= grant;
            if (grant) begin
                fifo_din <= win_data;
                grant_id <= winner;
                rr_ptr   <= rr_next;
            end
            credits <= credits - CW'(grant) + CW'(pop_ok);
            if (fifo_rd && (credits == DEPTH_C))
                err <= 1'b1;
        end
    end
endmodule
